// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pattern_scheduler
// Description : Round-robin refill scheduler that streams a command list to
//               requesting lanes and accumulates lane hits into a score.
//               Optional macro SCORE_SAT_EN makes the score saturate at 8'hFF
//               instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_scheduler #(
  parameter int N_LANES  = 8,
  parameter int LIST_LEN = 203,
  parameter int CMD_W    = 4
) (
  input  logic               CLOCK_25,
  input  logic               rst_n,
  input  logic [N_LANES-1:0] req,
  input  logic [N_LANES-1:0] ponto,
  output logic [7:0]         cmd_rd_addr,
  input  logic [CMD_W-1:0]   cmd_rd_data,
  output logic [N_LANES-1:0] grant,
  output logic [CMD_W-1:0]   grant_cmd,
  output logic               grant_valid,
  output logic [7:0]         score,
  output logic               fim_de_jogo
);

  localparam int c_IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST_LANE = c_IDX_W'(N_LANES - 1);
  localparam logic [8:0] c_LIST_END = 9'(LIST_LEN);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_GRANT = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]         r_state;
  logic [N_LANES-1:0] r_req_q;
  logic [N_LANES-1:0] r_ponto_q;
  logic [N_LANES-1:0] r_pending;
  logic [c_IDX_W-1:0] r_sel;
  logic [c_IDX_W-1:0] r_last;
  logic [8:0]         r_ptr;
  logic [7:0]         r_score;
  logic               r_fim;

  logic [N_LANES-1:0] w_req_rise;
  logic [N_LANES-1:0] w_ponto_rise;
  logic [N_LANES-1:0] w_clr;
  logic [N_LANES-1:0] w_pending_next;
  logic [N_LANES-1:0] w_grant;
  logic [CMD_W-1:0]   w_grant_cmd;
  logic               w_grant_valid;
  logic [c_IDX_W-1:0] w_done_pick;
  logic [8:0]         w_ptr_inc;
  logic [7:0]         w_hits;
  logic [8:0]         w_score_sum;
  logic [7:0]         w_score_next;

  // First candidate found walking upward from the lane after 'last'.
  function automatic logic [c_IDX_W-1:0] f_rr_pick(
    input logic [N_LANES-1:0] cands,
    input logic [c_IDX_W-1:0] last
  );
    logic [c_IDX_W-1:0] pick;
    logic [c_IDX_W-1:0] lane;
    int                 idx;
    pick = last;
    for (int off = N_LANES; off >= 1; off--) begin
      idx = int'(last) + off;
      if (idx >= N_LANES) idx = idx - N_LANES;
      lane = c_IDX_W'(idx);
      if (cands[lane]) pick = lane;
    end
    return pick;
  endfunction

  function automatic logic [N_LANES-1:0] f_onehot(input logic [c_IDX_W-1:0] idx);
    return N_LANES'(1) << idx;
  endfunction

  assign w_req_rise   = req & ~r_req_q;
  assign w_ponto_rise = ponto & ~r_ponto_q;
  assign w_ptr_inc    = r_ptr + 9'd1;
  assign w_done_pick  = f_rr_pick(r_pending, r_last);

  always_comb begin
    w_grant       = '0;
    w_grant_cmd   = '0;
    w_grant_valid = 1'b0;
    case (r_state)
      c_GRANT: begin
        w_grant       = f_onehot(r_sel);
        w_grant_cmd   = cmd_rd_data;
        w_grant_valid = 1'b1;
      end
      c_DONE: begin
        // List exhausted: lanes still get a grant, carrying the empty command.
        if (|r_pending) begin
          w_grant       = f_onehot(w_done_pick);
          w_grant_valid = 1'b1;
        end
      end
      default: begin
        w_grant       = '0;
        w_grant_cmd   = '0;
        w_grant_valid = 1'b0;
      end
    endcase
  end

  // A fresh edge in the clearing cycle keeps the lane pending.
  assign w_clr          = w_grant_valid ? w_grant : '0;
  assign w_pending_next = (r_pending & ~w_clr) | w_req_rise;

  always_comb begin
    w_hits = '0;
    for (int i = 0; i < N_LANES; i++) begin
      w_hits = w_hits + 8'(w_ponto_rise[i]);
    end
  end

  assign w_score_sum = {1'b0, r_score} + {1'b0, w_hits};

`ifdef SCORE_SAT_EN
  assign w_score_next = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];
`else
  assign w_score_next = w_score_sum[7:0];
`endif

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_req_q   <= '0;
      r_ponto_q <= '0;
      r_pending <= '0;
      r_score   <= '0;
    end else begin
      r_req_q   <= req;
      r_ponto_q <= ponto;
      r_pending <= w_pending_next;
      r_score   <= w_score_next;
    end
  end

  always_ff @(posedge CLOCK_25 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_sel   <= '0;
      r_last  <= c_LAST_LANE;
      r_ptr   <= '0;
      r_fim   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (|r_pending) begin
            r_sel   <= f_rr_pick(r_pending, r_last);
            r_state <= c_FETCH;
          end
        end
        c_FETCH: begin
          r_state <= c_GRANT;
        end
        c_GRANT: begin
          r_ptr  <= w_ptr_inc;
          r_last <= r_sel;
          if (w_ptr_inc == c_LIST_END) begin
            r_state <= c_DONE;
            r_fim   <= 1'b1;
          end else if (|w_pending_next) begin
            // Back-to-back: arbitrate now so the next ROM fetch starts at once.
            r_sel   <= f_rr_pick(w_pending_next, r_sel);
            r_state <= c_FETCH;
          end else begin
            r_state <= c_IDLE;
          end
        end
        c_DONE: begin
          if (|r_pending) r_last <= w_done_pick;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign cmd_rd_addr = r_ptr[7:0];
  assign grant       = w_grant;
  assign grant_cmd   = w_grant_cmd;
  assign grant_valid = w_grant_valid;
  assign score       = r_score;
  assign fim_de_jogo = r_fim;

endmodule
`default_nettype wire
